hist_eq_pass_sequencer: RTL and testbench
=========================================

# hist_eq_pass_sequencer

Control sequencer for the histogram-equalization core. Starts from the AXI-Lite start register and runs the full flow:
- clear histogram bins;
- pass 1: accumulate T_TOTAL pixels;
- CDF computation;
- pass 2: remap T_TOTAL pixels;
- raise a completion pulse.

It sits between the AXI-Lite register file and the histogram/CDF/LUT datapath. It owns S_AXIS_TREADY and generates the output TLAST.

## Interface
Clock and reset: one clock; reset is asynchronous and active-low (S_AXI_ACLK, S_AXI_ARESETN).

Parameters
- NBINS, 256, histogram bins; the clear counter walks 0..NBINS-1.
- CNT_W, 32, pixel counter and cfg_t_total width.
- WDOG_CYCLES, 65536, watchdog limit (used only with the macro).

Ports
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  async active-low reset.
- cfg_start  in  1  one-cycle pulse from the slv_reg0 write.
- cfg_abort  in  1  one-cycle pulse; abort to IDLE.
- cfg_t_total  in  CNT_W  pixel count (slv_reg1); latched on accepted start.
- S_AXIS_TVALID  in  1  input stream valid.
- S_AXIS_TLAST  in  1  input stream last.
- S_AXIS_TREADY  out  1  input stream ready.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TLAST  out  1  output last, pass 2 only.
- hist_clr  out  1  bin clear write enable.
- hist_clr_addr  out  8  bin address being cleared.
- hist_we  out  1  pass-1 pixel accepted.
- map_en  out  1  pass-2 pixel accepted.
- cdf_start  out  1  one-cycle CDF kick.
- cdf_done  in  1  CDF-complete pulse from the datapath.
- busy  out  1  state != IDLE.
- done_irq  out  1  one-cycle completion pulse.
- err_tlast  out  1  sticky: TLAST position did not match the count.
- err_cfg  out  1  sticky: start received with t_total == 0.
- err_timeout  out  1  sticky: watchdog fired (0 without the macro).
- state_o  out  3  current state code.

## Operation
- State codes: IDLE=0, CLEAR=1, PASS1=2, CDF=3, PASS2=4, DONE=5.
- **IDLE**
  - cfg_start with cfg_t_total != 0: latch t_total, clear pix_cnt, clear all sticky errors, go to CLEAR.
  - cfg_start with cfg_t_total == 0: set err_cfg, stay in IDLE.
- **CLEAR**
  - hist_clr=1 and hist_clr_addr = clr_cnt, for NBINS cycles.
  - After address NBINS-1, go to PASS1.
- **PASS1**
  - S_AXIS_TREADY = 1.
  - Beat = TVALID & TREADY. On a beat: hist_we=1 and pix_cnt increments.
  - Beat with pix_cnt == t_total-1: pix_cnt <= 0, go to CDF.
- **CDF**
  - cdf_start=1 for exactly the first cycle in the state.
  - S_AXIS_TREADY = 0.
  - Wait for cdf_done, then go to PASS2.
- **PASS2**
  - S_AXIS_TREADY = M_AXIS_TREADY.
  - On a beat: map_en=1 and pix_cnt increments.
  - M_AXIS_TLAST = 1 whenever pix_cnt == t_total-1.
  - Last beat goes to DONE.
- **DONE**: done_irq=1 for one cycle, then IDLE.
- **TLAST check** (both passes): set err_tlast if either
  - TLAST=1 on a beat with pix_cnt != t_total-1, or
  - TLAST=0 on the final beat.
  
  Pass length is governed only by t_total, never by TLAST.
- **Start and abort**
  - cfg_start outside IDLE is ignored.
  - cfg_abort in any state: next state IDLE, pix_cnt and clr_cnt cleared, sticky errors kept.
  - cfg_abort and cfg_start in the same cycle: abort wins.
- cfg_t_total changes after the start is accepted have no effect until the next start.

## Timing
- Reset values: state IDLE, all counters 0, every output 0, including S_AXIS_TREADY and all error flags.
- The state register, counters and error flags are registered. S_AXIS_TREADY, hist_we, map_en, hist_clr, hist_clr_addr and M_AXIS_TLAST are combinational from registered state, counters and the AXIS inputs.
- cdf_start and done_irq are registered pulses, asserted the cycle the state register holds CDF or DONE respectively.
- Latencies:
  - start → first hist_clr: 1 cycle.
  - Start to first possible pass-1 beat: NBINS+1 cycles.
  - Last pass-1 beat → cdf_start: 1 cycle.
  - cdf_done → S_AXIS_TREADY in PASS2: 1 cycle.
- cdf_done outside CDF is ignored.
- Reset asserted mid-operation: outputs return to reset values asynchronously.

## Configuration
- Macro: HIST_EQ_WATCHDOG_EN.
- Defined: a watchdog counter runs in PASS1, CDF and PASS2.
  - It is cleared on every beat, on cdf_done and on every state change.
  - When it reaches WDOG_CYCLES-1: set err_timeout and go to IDLE without done_irq.
- Not defined: no watchdog counter exists, err_timeout is tied to 0, and the block waits indefinitely.

## Structure
- Shared package hist_eq_pkg holds:
  - the state enum (codes above);
  - NBINS_DEF, CNT_W_DEF;
  - the WDOG_CYCLES default.
- Single module. No sub-module: the optional watchdog is an inline `ifdef block.

## Test plan
- **Normal flow:** t_total=16, start, 16 beats each with TLAST on beat 16, cdf_done 5 cycles after cdf_start.
  - 256 hist_clr cycles with addresses 0..255.
  - 16 hist_we, one cdf_start, 16 map_en.
  - M_AXIS_TLAST only on pass-2 beat 16.
  - done_irq once; err_tlast=0.
- **Zero config:** start with t_total=0.
  - err_cfg=1, busy=0, no hist_clr.
- **TLAST mismatch:** t_total=8, TLAST on beat 5 of pass 1.
  - err_tlast=1; pass 1 still ends after 8 beats; CDF is entered.
- **Backpressure:** in PASS2 toggle M_AXIS_TREADY every cycle, t_total=8.
  - S_AXIS_TREADY follows it; exactly 8 map_en; done_irq once.
- **Abort and restart:** cfg_abort during PASS1 at beat 3; then start again with t_total=4.
  - IDLE next cycle; the rerun completes with 4+4 beats and done_irq.
- **Watchdog** (macro defined, WDOG_CYCLES=64): hold cdf_done low.
  - err_timeout=1 after 64 CDF cycles; IDLE; no done_irq.

Source files
------------

// File: rtl/hist_eq_pkg.sv
// hist_eq_pkg: shared definitions for the histogram-equalization control path.
//   state_t          - sequencer state codes (IDLE=0 .. DONE=5, exposed on state_o)
//   NBINS_DEF        - default number of histogram bins
//   CNT_W_DEF        - default pixel counter / t_total width
//   WDOG_CYCLES_DEF  - default watchdog limit (only used with HIST_EQ_WATCHDOG_EN)
package hist_eq_pkg;

  localparam int NBINS_DEF       = 256;
  localparam int CNT_W_DEF       = 32;
  localparam int WDOG_CYCLES_DEF = 65536;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_PASS1 = 3'd2,
    ST_CDF   = 3'd3,
    ST_PASS2 = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/hist_eq_pass_sequencer.sv
// hist_eq_pass_sequencer: control sequencer for the histogram-equalization core.
// Flow per start: clear NBINS bins -> pass 1 (accumulate t_total pixels) ->
// CDF computation -> pass 2 (remap t_total pixels) -> done_irq pulse.
//
// Ports
//   S_AXI_ACLK / S_AXI_ARESETN    clock, asynchronous active-low reset
//   cfg_start / cfg_abort         one-cycle control pulses (abort wins)
//   cfg_t_total                   pixel count, latched on an accepted start
//   S_AXIS_TVALID/TLAST/TREADY    input stream handshake (TREADY owned here)
//   M_AXIS_TREADY / M_AXIS_TLAST  downstream ready, pass-2 output last
//   hist_clr / hist_clr_addr      bin clear strobe and address
//   hist_we / map_en              pass-1 / pass-2 pixel accepted
//   cdf_start / cdf_done          CDF kick (registered pulse) and completion
//   busy / done_irq / state_o     status
//   err_tlast / err_cfg / err_timeout  sticky error flags
//
// Build option: define HIST_EQ_WATCHDOG_EN to add a stall watchdog in
// PASS1/CDF/PASS2; without it err_timeout is constant 0.
module hist_eq_pass_sequencer
  import hist_eq_pkg::*;
#(
  parameter int NBINS       = NBINS_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic [CNT_W-1:0] cfg_t_total,
  input  logic             S_AXIS_TVALID,
  input  logic             S_AXIS_TLAST,
  output logic             S_AXIS_TREADY,
  input  logic             M_AXIS_TREADY,
  output logic             M_AXIS_TLAST,
  output logic             hist_clr,
  output logic [7:0]       hist_clr_addr,
  output logic             hist_we,
  output logic             map_en,
  output logic             cdf_start,
  input  logic             cdf_done,
  output logic             busy,
  output logic             done_irq,
  output logic             err_tlast,
  output logic             err_cfg,
  output logic             err_timeout,
  output logic [2:0]       state_o
);

  localparam int CLR_W = $clog2(NBINS);

  if (NBINS < 2 || NBINS > 256 || WDOG_CYCLES < 2) begin : g_bad_params
    $error("hist_eq_pass_sequencer: NBINS must be 2..256 and WDOG_CYCLES >= 2");
  end

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   t_total_reg;
  logic [CNT_W-1:0]   pix_cnt_reg;
  logic [CLR_W-1:0]   clr_cnt_reg;
  logic               cdf_start_reg, done_irq_reg;
  logic               err_tlast_reg, err_cfg_reg;
  logic               s_ready, beat, pix_last, clr_last;
  logic               start_accept, start_zero, wdog_fire;

  assign pix_last     = (pix_cnt_reg == t_total_reg - CNT_W'(1));
  assign clr_last     = (clr_cnt_reg == CLR_W'(NBINS - 1));
  assign beat         = S_AXIS_TVALID & s_ready;
  // Abort in the same cycle cancels a start entirely, including err_cfg.
  assign start_accept = (state_reg == ST_IDLE) & cfg_start & ~cfg_abort & (cfg_t_total != '0);
  assign start_zero   = (state_reg == ST_IDLE) & cfg_start & ~cfg_abort & (cfg_t_total == '0);

  // State register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state_reg <= ST_IDLE;
    else                state_reg <= state_next;
  end

  // Next-state logic; watchdog and abort override the normal flow.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start_accept)      state_next = ST_CLEAR;
      ST_CLEAR: if (clr_last)          state_next = ST_PASS1;
      ST_PASS1: if (beat && pix_last)  state_next = ST_CDF;
      ST_CDF:   if (cdf_done)          state_next = ST_PASS2;
      ST_PASS2: if (beat && pix_last)  state_next = ST_DONE;
      ST_DONE:                         state_next = ST_IDLE;
      default:                         state_next = ST_IDLE;
    endcase
    if (wdog_fire) state_next = ST_IDLE;
    if (cfg_abort) state_next = ST_IDLE;
  end

  // Combinational outputs from registered state/counters and stream inputs.
  always_comb begin
    s_ready      = 1'b0;
    hist_we      = 1'b0;
    map_en       = 1'b0;
    hist_clr     = 1'b0;
    M_AXIS_TLAST = 1'b0;
    case (state_reg)
      ST_CLEAR: hist_clr = 1'b1;
      ST_PASS1: begin
        s_ready = 1'b1;
        hist_we = S_AXIS_TVALID;
      end
      ST_PASS2: begin
        s_ready      = M_AXIS_TREADY;
        map_en       = S_AXIS_TVALID & M_AXIS_TREADY;
        M_AXIS_TLAST = pix_last;
      end
      default: ;
    endcase
  end

  assign S_AXIS_TREADY = s_ready;
  assign hist_clr_addr = 8'(clr_cnt_reg);
  assign busy          = (state_reg != ST_IDLE);
  assign state_o       = state_reg;
  assign cdf_start     = cdf_start_reg;
  assign done_irq      = done_irq_reg;
  assign err_tlast     = err_tlast_reg;
  assign err_cfg       = err_cfg_reg;

  // Counters, latched configuration, registered pulses and sticky errors.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      t_total_reg   <= '0;
      pix_cnt_reg   <= '0;
      clr_cnt_reg   <= '0;
      cdf_start_reg <= 1'b0;
      done_irq_reg  <= 1'b0;
      err_tlast_reg <= 1'b0;
      err_cfg_reg   <= 1'b0;
    end else begin
      // Pulses line up with the cycle the state register holds CDF / DONE.
      cdf_start_reg <= (state_next == ST_CDF) && (state_reg != ST_CDF);
      done_irq_reg  <= (state_next == ST_DONE);

      if (start_accept) t_total_reg <= cfg_t_total;

      if (cfg_abort || start_accept) begin
        pix_cnt_reg <= '0;
        clr_cnt_reg <= '0;
      end else begin
        if (state_reg == ST_CLEAR) clr_cnt_reg <= clr_last ? '0 : clr_cnt_reg + CLR_W'(1);
        if (beat)                  pix_cnt_reg <= pix_last ? '0 : pix_cnt_reg + CNT_W'(1);
      end

      if (start_accept) begin
        err_tlast_reg <= 1'b0;
        err_cfg_reg   <= 1'b0;
      end else begin
        if (start_zero) err_cfg_reg <= 1'b1;
        // TLAST must be high on exactly the t_total-th beat; it never ends a pass.
        if (beat && (S_AXIS_TLAST != pix_last)) err_tlast_reg <= 1'b1;
      end
    end
  end

`ifdef HIST_EQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES);

  logic [WD_W-1:0] wdog_cnt_reg;
  logic            wdog_active, err_timeout_reg;

  assign wdog_active = (state_reg == ST_PASS1) || (state_reg == ST_CDF) || (state_reg == ST_PASS2);
  assign wdog_fire   = wdog_active && (wdog_cnt_reg == WD_W'(WDOG_CYCLES - 1));
  assign err_timeout = err_timeout_reg;

  // Any sign of progress (beat, cdf_done, state change) restarts the count.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wdog_cnt_reg    <= '0;
      err_timeout_reg <= 1'b0;
    end else begin
      if (!wdog_active || beat || cdf_done || (state_next != state_reg))
        wdog_cnt_reg <= '0;
      else
        wdog_cnt_reg <= wdog_cnt_reg + WD_W'(1);

      if (start_accept)   err_timeout_reg <= 1'b0;
      else if (wdog_fire) err_timeout_reg <= 1'b1;
    end
  end
`else
  assign wdog_fire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_hist_eq_pass_sequencer.sv
// tb_hist_eq_pass_sequencer: randomized self-checking bench for
// hist_eq_pass_sequencer. Each run is planned at transaction level (pixel
// count, which beat carries a wrong TLAST, CDF latency, backpressure style,
// optional abort point) and the expected handshake/strobe/error behaviour is
// derived from that plan. Prints one line per run and a final summary.
module tb_hist_eq_pass_sequencer;
  import hist_eq_pkg::*;

  localparam int NBINS = 256;
  localparam int CNT_W = 32;
  localparam int WDOG  = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_start = 1'b0, cfg_abort = 1'b0;
  logic [CNT_W-1:0] cfg_t_total = '0;
  logic             s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b0, cdf_done = 1'b0;
  logic             s_tready, m_tlast, hist_clr, hist_we, map_en, cdf_start;
  logic             busy, done_irq, err_tlast, err_cfg, err_timeout;
  logic [7:0]       hist_clr_addr;
  logic [2:0]       state_o;

  int checks = 0, failures = 0;
  int cnt_clr, cnt_we, cnt_map, cnt_cdf, cnt_done, cnt_mlast;

  always #5 clk = ~clk;

  hist_eq_pass_sequencer #(.NBINS(NBINS), .CNT_W(CNT_W), .WDOG_CYCLES(WDOG)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_t_total(cfg_t_total),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast), .S_AXIS_TREADY(s_tready),
    .M_AXIS_TREADY(m_tready), .M_AXIS_TLAST(m_tlast),
    .hist_clr(hist_clr), .hist_clr_addr(hist_clr_addr),
    .hist_we(hist_we), .map_en(map_en),
    .cdf_start(cdf_start), .cdf_done(cdf_done),
    .busy(busy), .done_irq(done_irq),
    .err_tlast(err_tlast), .err_cfg(err_cfg), .err_timeout(err_timeout),
    .state_o(state_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Event monitor: counts strobes per run and checks the clear address walk.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hist_clr) begin
        check("clr_addr", 64'(hist_clr_addr), 64'(cnt_clr % NBINS));
        cnt_clr++;
      end
      if (hist_we)           cnt_we++;
      if (map_en)            cnt_map++;
      if (cdf_start)         cnt_cdf++;
      if (done_irq)          cnt_done++;
      if (map_en && m_tlast) cnt_mlast++;
    end
  end

  // One full run. bad1/bad2: beat index (0-based) whose TLAST is inverted, -1 none.
  // cdf_delay < 0 holds cdf_done low (watchdog run). abort_at: abort when that
  // many pass-1 beats are done, -1 none. bp=1 toggles M_AXIS_TREADY each cycle.
  task automatic run_flow(input int n, input int bad1, input int bad2,
                          input int cdf_delay, input int bp, input int abort_at);
    int   cyc, beat;
    logic exp_rdy, m_rdy;
    $display("run n=%0d bad1=%0d bad2=%0d cdf_delay=%0d bp=%0d abort_at=%0d",
             n, bad1, bad2, cdf_delay, bp, abort_at);
    cnt_clr = 0; cnt_we = 0; cnt_map = 0; cnt_cdf = 0; cnt_done = 0; cnt_mlast = 0;

    @(posedge clk); #1;
    cfg_t_total = CNT_W'(n); cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0; cfg_t_total = $urandom;   // later changes must not matter
    @(negedge clk);
    check("start_clr", hist_clr, 1'b1);
    check("start_busy", busy, 1'b1);
    check("start_rdy", s_tready, 1'b0);

    // Clear phase + pass 1: ready exactly from cycle NBINS after CLEAR entry.
    cyc = 0; beat = 0;
    while (beat < n && cyc < NBINS + 40 * n + 40) begin
      @(posedge clk); #1; cyc++;
      if (abort_at >= 0 && beat == abort_at && cyc >= NBINS) begin
        s_tvalid = 1'b0; cdf_done = 1'b0;
        cfg_abort = 1'b1; cfg_start = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        cfg_abort = 1'b0; cfg_start = 1'b0;
        @(negedge clk);
        check("abort_state", state_o, ST_IDLE);
        check("abort_busy", busy, 1'b0);
        check("abort_rdy", s_tready, 1'b0);
        check("abort_err_kept", err_tlast, (bad1 >= 0 && bad1 < beat));
        return;
      end
      s_tvalid    = ($urandom_range(0, 3) != 0);
      s_tlast     = (beat == n - 1) ^ (beat == bad1);
      cdf_done    = ($urandom_range(0, 7) == 0);
      cfg_start   = ($urandom_range(0, 15) == 0);
      cfg_t_total = $urandom;
      @(negedge clk);
      exp_rdy = (cyc >= NBINS);
      check("p1_ready", s_tready, exp_rdy);
      check("p1_clr", hist_clr, cyc < NBINS);
      check("p1_we", hist_we, s_tvalid && exp_rdy);
      check("p1_map", map_en, 1'b0);
      if (s_tvalid && exp_rdy) beat++;
    end
    check("p1_beats", 64'(beat), 64'(n));

    // CDF: kick visible the cycle after the last pass-1 beat.
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0; cdf_done = 1'b0; cfg_start = 1'b0;
    @(negedge clk);
    check("cdf_start", cdf_start, 1'b1);
    check("cdf_state", state_o, ST_CDF);
    check("cdf_rdy", s_tready, 1'b0);
`ifdef HIST_EQ_WATCHDOG_EN
    if (cdf_delay < 0) begin
      repeat (WDOG - 1) @(negedge clk);
      check("wd_hold", state_o, ST_CDF);
      @(negedge clk);
      check("wd_state", state_o, ST_IDLE);
      check("wd_err", err_timeout, 1'b1);
      check("wd_no_irq", 64'(cnt_done), 64'd0);
      return;
    end
`endif
    repeat (cdf_delay) @(posedge clk);
    #1 cdf_done = 1'b1;

    // Pass 2: ready follows downstream ready, TLAST out on the final position.
    cyc = 0; beat = 0; m_rdy = 1'($urandom_range(0, 1));
    while (beat < n && cyc < 60 * n + 60) begin
      @(posedge clk); #1; cyc++;
      cdf_done    = ($urandom_range(0, 7) == 0);
      m_rdy       = (bp == 1) ? ~m_rdy : ($urandom_range(0, 2) != 0);
      m_tready    = m_rdy;
      s_tvalid    = ($urandom_range(0, 3) != 0);
      s_tlast     = (beat == n - 1) ^ (beat == bad2);
      cfg_start   = ($urandom_range(0, 15) == 0);
      cfg_t_total = $urandom;
      @(negedge clk);
      check("p2_ready", s_tready, m_rdy);
      check("p2_map", map_en, s_tvalid && m_rdy);
      check("p2_mtlast", m_tlast, beat == n - 1);
      check("p2_we", hist_we, 1'b0);
      if (s_tvalid && m_rdy) beat++;
    end
    check("p2_beats", 64'(beat), 64'(n));

    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0; cdf_done = 1'b0; cfg_start = 1'b0; m_tready = 1'b0;
    @(negedge clk);
    check("done_irq", done_irq, 1'b1);
    check("done_state", state_o, ST_DONE);
    check("done_rdy", s_tready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_state", state_o, ST_IDLE);
    check("idle_busy", busy, 1'b0);
    check("irq_pulse", done_irq, 1'b0);

    check("n_clr", 64'(cnt_clr), 64'(NBINS));
    check("n_we", 64'(cnt_we), 64'(n));
    check("n_cdf", 64'(cnt_cdf), 64'd1);
    check("n_map", 64'(cnt_map), 64'(n));
    check("n_mtlast", 64'(cnt_mlast), 64'd1);
    check("n_done", 64'(cnt_done), 64'd1);
    check("err_tlast", err_tlast, (bad1 >= 0) || (bad2 >= 0));
    check("err_cfg_clr", err_cfg, 1'b0);
    check("err_timeout", err_timeout, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int n, b1, b2;
    // Reset state, asserted and then released.
    repeat (3) @(negedge clk);
    check("rst_state", state_o, ST_IDLE);
    check("rst_busy", busy, 1'b0);
    check("rst_rdy", s_tready, 1'b0);
    check("rst_errs", {err_tlast, err_cfg, err_timeout}, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_pulses", {cdf_start, done_irq, hist_clr}, 3'b000);

    // Zero t_total: error only, stays idle.
    @(posedge clk); #1; cfg_t_total = '0; cfg_start = 1'b1;
    @(posedge clk); #1; cfg_start = 1'b0;
    @(negedge clk);
    $display("zero-config start");
    check("zero_err_cfg", err_cfg, 1'b1);
    check("zero_busy", busy, 1'b0);
    check("zero_clr", hist_clr, 1'b0);

    // Abort together with start: abort wins.
    @(posedge clk); #1; cfg_t_total = 32'd5; cfg_start = 1'b1; cfg_abort = 1'b1;
    @(posedge clk); #1; cfg_start = 1'b0; cfg_abort = 1'b0;
    @(negedge clk);
    $display("start+abort same cycle");
    check("sa_busy", busy, 1'b0);
    check("sa_clr", hist_clr, 1'b0);

    run_flow(16, -1, -1, 5, 0, -1);   // normal flow
    run_flow(8, 4, -1, 2, 0, -1);     // TLAST on pass-1 beat 5
    run_flow(8, -1, -1, 1, 1, -1);    // toggling backpressure
    run_flow(8, 1, -1, 0, 0, 3);      // abort after 3 beats, error kept
    run_flow(4, -1, -1, 3, 0, -1);    // restart completes and clears errors
    for (int i = 0; i < 6; i++) begin
      n  = $urandom_range(1, 20);
      b1 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      b2 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run_flow(n, b1, b2, int'($urandom_range(0, 6)), int'($urandom_range(0, 1)), -1);
    end
`ifdef HIST_EQ_WATCHDOG_EN
    run_flow(4, -1, -1, -1, 0, -1);   // cdf_done never arrives
`endif

    // Reset mid-operation: outputs drop without waiting for a clock edge.
    @(posedge clk); #1; cfg_t_total = 32'd8; cfg_start = 1'b1;
    @(posedge clk); #1; cfg_start = 1'b0;
    repeat (20) @(negedge clk);
    $display("async reset during CLEAR");
    check("mid_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_state", state_o, ST_IDLE);
    check("mid_rst_outs", {busy, hist_clr, s_tready}, 3'b000);
    check("mid_rst_addr", hist_clr_addr, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
